xor_frame_check: RTL
====================

XOR_FRAME_CHECK -- requirements
Module: xor_frame_check

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 8: beats per frame, legal range 1..255.
REQ-002 The block SHALL have parameter CNT_W, default 4: width of the error counter.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream beat valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block accepts a beat.
REQ-007 The block SHALL have port in_c, input, 3 bits: 3-bit code word from the upstream XOR stage.
REQ-008 The block SHALL have port in_z, input, 1 bit: upstream parity flag, expected to equal in_c[1]^in_c[0].
REQ-009 The block SHALL have port out_valid, output, 1 bit: frame result valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 The block SHALL have port out_acc, output, 3 bits: XOR of all in_c words in the frame.
REQ-012 The block SHALL have port out_err, output, CNT_W bits: count of parity-mismatched beats in the frame.

Function
REQ-013 A beat transfer SHALL occur on a rising clk edge where in_valid=1 and in_ready=1; no other cycle changes frame state.
REQ-014 Beat mismatch SHALL be defined as in_z != (in_c[1]^in_c[0]).
REQ-015 The FSM SHALL have states IDLE, ACCUM and DONE; in_ready=1 in IDLE and ACCUM and 0 in DONE; out_valid=1 only in DONE.
REQ-016 In IDLE, a transfer SHALL load acc=in_c, beat count=1 and err=mismatch, then go to DONE if FRAME_LEN=1, else to ACCUM.
REQ-017 In ACCUM, each transfer SHALL set acc^=in_c, increment beat count and add mismatch to err; the transfer that makes beat count equal FRAME_LEN SHALL move to DONE.
REQ-018 err SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-019 out_valid SHALL rise in the cycle after the final beat transfer (1-cycle latency).
REQ-020 In DONE, out_acc and out_err SHALL hold stable while out_ready=0, and in_valid SHALL be ignored.
REQ-021 In DONE with out_ready=1, the next state SHALL be IDLE with acc, err and beat count cleared; in_ready rises in that cycle and no beat is accepted on the handoff edge.
REQ-022 Cycles with in_valid=0 (bubbles) SHALL leave all state unchanged.
REQ-023 Outside DONE, out_acc and out_err SHALL show the running values; they are valid to sample only while out_valid=1.

Reset
REQ-024 While rst=1, the state SHALL be IDLE with acc=0, err=0 and beat count=0; out_valid=0, out_acc=3'b000, out_err=0 and in_ready=1.
REQ-025 Asserting rst mid-frame or in DONE SHALL discard the partial or pending result immediately, without waiting for clk.
REQ-026 After rst deasserts, the first transfer SHALL start a new frame per REQ-016.

Verification (FRAME_LEN=4, CNT_W=4 unless stated)
REQ-027 Reset check: assert rst asynchronously mid-cycle -> out_valid=0, out_acc=000 and out_err=0 at once; in_ready=1 after release.
REQ-028 Clean frame: beats (c,z) = (001,1), (010,1), (011,0), (100,0) -> the cycle after the 4th transfer, out_valid=1, out_acc=100 and out_err=0.
REQ-029 Error frame: four beats (000,1) -> out_acc=000 and out_err=4; with CNT_W=2 and FRAME_LEN=6, six mismatched beats -> out_err=3 (saturated).
REQ-030 Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 -> outputs stable, in_ready=0, nothing accepted; then out_ready=1 -> next cycle out_valid=0, in_ready=1, and the following frame is unaffected.
REQ-031 Bubbles: insert 0-3 idle cycles between the REQ-028 beats -> identical result (out_acc=100, out_err=0).
REQ-032 Mid-frame reset: after 2 beats of (111,1), pulse rst, then send the REQ-028 frame -> out_acc=100 and out_err=0, with no carry-over from the discarded beats.

Source files
------------

// File: rtl/xor_frame_check.sv
// Frame checker for a 3-bit XOR stage: folds FRAME_LEN code words into one XOR result
// and counts beats whose parity flag disagrees with in_c[1]^in_c[0].
module xor_frame_check #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_c,
  input  logic             in_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_acc,
  output logic [CNT_W-1:0] out_err
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam logic [7:0] LAST_BEAT = 8'(FRAME_LEN);

  state_t           state, state_next;
  logic [2:0]       acc, acc_next;
  logic [CNT_W-1:0] err, err_next;
  logic [7:0]       cnt, cnt_next;
  logic [7:0]       cnt_inc;
  logic             take;
  logic             mismatch;
  logic [CNT_W-1:0] err_sat;

  assign mismatch = in_z ^ in_c[1] ^ in_c[0];
  assign cnt_inc  = cnt + 8'd1;

  // Saturating add: once the counter is full, further mismatches are dropped.
  assign err_sat = (err == '1) ? err : err + CNT_W'(mismatch);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      err   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      err   <= err_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    acc_next   = acc;
    err_next   = err;
    cnt_next   = cnt;
    in_ready   = (state != DONE);
    out_valid  = (state == DONE);
    take       = in_valid && (state != DONE);

    case (state)
      IDLE: begin
        if (take) begin
          acc_next   = in_c;
          err_next   = CNT_W'(mismatch);
          cnt_next   = 8'd1;
          state_next = (FRAME_LEN == 1) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (take) begin
          acc_next = acc ^ in_c;
          err_next = err_sat;
          cnt_next = cnt_inc;
          if (cnt_inc == LAST_BEAT) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        // Handoff edge only clears; a beat offered here is not taken.
        if (out_ready) begin
          acc_next   = '0;
          err_next   = '0;
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        acc_next   = '0;
        err_next   = '0;
        cnt_next   = '0;
      end
    endcase
  end

  assign out_acc = acc;
  assign out_err = err;

endmodule
